// File: rtl/canvas_write_controller_pkg.sv
// Shared types and default geometry for the overlay framebuffer write controller.
// Colour codes, FSM states and the counter-width helper live here.
package canvas_write_controller_pkg;

  typedef enum logic [2:0] {
    ERASE  = 3'd0,
    WHITE  = 3'd1,
    BLACK  = 3'd2,
    RED    = 3'd3,
    BLUE   = 3'd4,
    YELLOW = 3'd5,
    GREEN  = 3'd6,
    PURPLE = 3'd7
  } color_t;

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int BRUSH_DEF   = 4;
  localparam int ADDR_W_DEF  = 19;
  localparam int COLOR_W_DEF = 3;
  localparam int MX_W        = 10;
  localparam int MY_W        = 9;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/canvas_write_controller_if.sv
// Framebuffer write port: valid (fb_we) / ready (fb_ready) handshake with address and data.
// Address and data hold while fb_we is high and fb_ready is low.
interface canvas_write_controller_if
  import canvas_write_controller_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
);
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               fb_ready;

  modport master (output fb_we, output fb_addr, output fb_wdata, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_wdata, output fb_ready);
endinterface

// File: rtl/canvas_write_controller_stamp_scan.sv
// Row-major BRUSH x BRUSH slot scanner: presents the address/clip of the slot about to be loaded,
// either the first slot (i_start) or the successor of the current one. Moves only on start/advance.
module canvas_write_controller_stamp_scan
  import canvas_write_controller_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int BRUSH  = BRUSH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_advance,
  input  logic [MX_W-1:0]   i_x0,
  input  logic [MY_W-1:0]   i_y0,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_clip,
  output logic              o_last
);
  localparam int X_W = MX_W + 1;
  localparam int Y_W = MY_W + 1;
  localparam int C_W = cnt_w(BRUSH);
  localparam logic [X_W-1:0]    X_LIM    = X_W'(H_RES);
  localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
  localparam logic [C_W-1:0]    C_MAX    = C_W'(BRUSH - 1);

  logic [X_W-1:0]    r_x0, r_x, w_x;
  logic [Y_W-1:0]    r_y, w_y;
  logic [ADDR_W-1:0] r_row, w_row;
  logic [C_W-1:0]    r_i, r_j;
  logic              w_row_end;

  assign w_row_end = (r_i == C_MAX);
  assign o_last    = w_row_end && (r_j == C_MAX);

  always_comb begin
    w_x   = r_x + 1'b1;
    w_y   = r_y;
    w_row = r_row;
    if (i_start) begin
      w_x   = {1'b0, i_x0};
      w_y   = {1'b0, i_y0};
      // Constant multiply once per stamp (shift-add); later rows step incrementally.
      w_row = ADDR_W'(i_y0) * ROW_STEP;
    end else if (w_row_end) begin
      w_x   = r_x0;
      w_y   = r_y + 1'b1;
      w_row = r_row + ROW_STEP;
    end
  end

  assign o_addr = w_row + ADDR_W'(w_x);
  assign o_clip = (w_x >= X_LIM) || (w_y >= Y_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_row <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (i_start) begin
      r_x0  <= {1'b0, i_x0};
      r_x   <= w_x;
      r_y   <= w_y;
      r_row <= w_row;
      r_i   <= '0;
      r_j   <= '0;
    end else if (i_advance) begin
      r_x   <= w_x;
      r_y   <= w_y;
      r_row <= w_row;
      r_i   <= w_row_end ? '0 : r_i + 1'b1;
      if (w_row_end) r_j <= r_j + 1'b1;
    end
  end

endmodule

// File: rtl/canvas_write_controller.sv
// Arbitrates brush stamps and full-screen clears onto the overlay framebuffer write port.
// Trigger in IDLE -> first write next cycle; fb_ready low stalls with address/data held.
module canvas_write_controller
  import canvas_write_controller_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int BRUSH   = BRUSH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MX_W-1:0]    i_mouse_x,
  input  logic [MY_W-1:0]    i_mouse_y,
  input  logic               i_button_left,
  input  logic               i_clear_req,
  input  logic [COLOR_W-1:0] i_color,
  canvas_write_controller_if.master fb,
  output logic               o_busy
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t             r_state, w_state;
  logic               r_pend, w_pend;
  logic               r_last_vld, w_last_vld;
  logic [MX_W-1:0]    r_last_x, w_last_x;
  logic [MY_W-1:0]    r_last_y, w_last_y;
  logic               r_we, w_we;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic [COLOR_W-1:0] r_wdata, w_wdata;
  logic               r_busy, w_busy;

  logic              w_trig, w_start, w_advance, w_slot_done;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_scan_clip, w_scan_last;

  assign w_trig      = i_button_left &&
                       (!r_last_vld || (i_mouse_x != r_last_x) || (i_mouse_y != r_last_y));
  assign w_start     = (r_state == IDLE) && !r_pend && w_trig;
  // A clipped slot has r_we low and therefore always completes in one cycle.
  assign w_slot_done = !r_we || fb.fb_ready;
  assign w_advance   = (r_state == STAMP) && w_slot_done && !w_scan_last;

  canvas_write_controller_stamp_scan #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .BRUSH (BRUSH),
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_advance(w_advance),
    .i_x0     (i_mouse_x),
    .i_y0     (i_mouse_y),
    .o_addr   (w_scan_addr),
    .o_clip   (w_scan_clip),
    .o_last   (w_scan_last)
  );

  always_comb begin
    w_state    = r_state;
    w_pend     = r_pend | i_clear_req;
    w_last_vld = r_last_vld;
    w_last_x   = r_last_x;
    w_last_y   = r_last_y;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    case (r_state)
      IDLE: begin
        if (r_pend) begin
          w_state    = CLEAR;
          w_pend     = i_clear_req;
          w_last_vld = 1'b0;
          w_we       = 1'b1;
          w_addr     = '0;
          w_wdata    = COLOR_W'(ERASE);
        end else if (w_trig) begin
          w_state    = STAMP;
          w_last_vld = 1'b1;
          w_last_x   = i_mouse_x;
          w_last_y   = i_mouse_y;
          w_we       = !w_scan_clip;
          w_addr     = w_scan_addr;
          w_wdata    = i_color;
        end else if (!i_button_left) begin
          w_last_vld = 1'b0;
        end
      end
      STAMP: begin
        if (w_slot_done) begin
          if (w_scan_last) begin
            w_state = IDLE;
            w_we    = 1'b0;
          end else begin
            w_we   = !w_scan_clip;
            w_addr = w_scan_addr;
          end
        end
      end
      CLEAR: begin
        if (fb.fb_ready) begin
          if (r_addr == LAST_ADDR) begin
            w_state = IDLE;
            w_we    = 1'b0;
          end else begin
            w_addr = r_addr + 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_we    = 1'b0;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      r_last_vld <= 1'b0;
      r_last_x   <= '0;
      r_last_y   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pend     <= w_pend;
      r_last_vld <= w_last_vld;
      r_last_x   <= w_last_x;
      r_last_y   <= w_last_y;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_busy     <= w_busy;
    end
  end

  assign fb.fb_we    = r_we;
  assign fb.fb_addr  = r_addr;
  assign fb.fb_wdata = r_wdata;
  assign o_busy      = r_busy;

endmodule
